// File: rtl/integral_image_gen.sv
// Streaming integral-image generator: per-row accumulator plus a line buffer of previous-row sums.
// Optional squared-integral path is enabled by defining IIG_SQSUM_EN.
module integral_image_gen #(
  parameter int MAX_WIDTH = 1024,
  parameter int SUM_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      width,
  input  logic [15:0]      height,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [47:0]      out_sqsum,
  output logic [31:0]      out_addr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [15:0]      width_r;
  logic [15:0]      height_r;
  logic [15:0]      col;
  logic [15:0]      row;
  logic [31:0]      addr;
  logic [SUM_W-1:0] racc;
  logic             last_taken;
  logic [SUM_W-1:0] lbuf [MAX_WIDTH];

  logic             take;
  logic             out_fire;
  logic             col_last;
  logic             row_last;
  logic             dims_ok;
  logic [AW-1:0]    col_idx;
  logic [SUM_W-1:0] lbuf_rd;
  logic [SUM_W-1:0] racc_next;
  logic [SUM_W-1:0] sum_next;

  assign in_ready = (state == RUN) && (!out_valid || out_ready) && !last_taken;
  assign take     = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state != IDLE);
  assign col_last = (col == width_r - 16'd1);
  assign row_last = (row == height_r - 16'd1);
  assign dims_ok  = (width != 16'd0) && (height != 16'd0) &&
                    (32'(width) <= 32'(MAX_WIDTH));
  assign col_idx  = col[AW-1:0];
  assign lbuf_rd  = lbuf[col_idx];

  // Row 0 never reads the line buffer, so stale contents from an earlier frame are harmless.
  assign racc_next = ((col == 16'd0) ? '0 : racc) + SUM_W'(in_pixel);
  assign sum_next  = racc_next + ((row == 16'd0) ? '0 : lbuf_rd);

  always_ff @(posedge clk) begin
    if (take) begin
      lbuf[col_idx] <= sum_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      width_r    <= '0;
      height_r   <= '0;
      col        <= '0;
      row        <= '0;
      addr       <= '0;
      racc       <= '0;
      last_taken <= 1'b0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_addr   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (dims_ok) begin
              width_r    <= width;
              height_r   <= height;
              col        <= '0;
              row        <= '0;
              addr       <= '0;
              last_taken <= 1'b0;
              state      <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          // The one-entry output stage refills in the same cycle it drains.
          if (take) begin
            racc      <= racc_next;
            out_sum   <= sum_next;
            out_addr  <= addr;
            out_valid <= 1'b1;
            addr      <= addr + 32'd1;
            if (col_last) begin
              col <= '0;
              row <= row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
            if (col_last && row_last) begin
              last_taken <= 1'b1;
            end
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
          if (last_taken && out_fire) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef IIG_SQSUM_EN
  logic [47:0] sqacc;
  logic [47:0] sqbuf [MAX_WIDTH];
  logic [15:0] sq_p;
  logic [47:0] sqacc_next;
  logic [47:0] sqsum_next;

  assign sq_p       = {8'd0, in_pixel} * {8'd0, in_pixel};
  assign sqacc_next = ((col == 16'd0) ? 48'd0 : sqacc) + 48'(sq_p);
  assign sqsum_next = sqacc_next + ((row == 16'd0) ? 48'd0 : sqbuf[col_idx]);

  always_ff @(posedge clk) begin
    if (take) begin
      sqbuf[col_idx] <= sqsum_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sqacc     <= '0;
      out_sqsum <= '0;
    end else if (take) begin
      sqacc     <= sqacc_next;
      out_sqsum <= sqsum_next;
    end
  end
`else
  assign out_sqsum = 48'd0;
`endif

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed, table-driven bench for integral_image_gen with hand-computed sums (MAX_WIDTH=8).
module tb_integral_image_gen;

  localparam int MAXW = 8;
`ifdef IIG_SQSUM_EN
  localparam bit SQ_EN = 1'b1;
`else
  localparam bit SQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] width;
  logic [15:0] height;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [47:0] out_sqsum;
  logic [31:0] out_addr;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  integral_image_gen #(.MAX_WIDTH(MAXW), .SUM_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .width(width), .height(height),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_sqsum(out_sqsum), .out_addr(out_addr), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [7:0]  pix;
    logic [31:0] sum;
    logic [47:0] sq;
  } vec_t;

  typedef struct {
    int w;
    int h;
    int first;
    int n;
  } frame_t;

  vec_t   vecs [30];
  frame_t frames [5];
  int     vectors = 0;
  int     miscompares = 0;

  logic [31:0] q_sum [$];
  logic [47:0] q_sq [$];
  logic [31:0] q_addr [$];
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;

  // Output monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_sum.push_back(out_sum);
      q_sq.push_back(out_sqsum);
      q_addr.push_back(out_addr);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic startFrame(input int w, input int h);
    start  = 1'b1;
    width  = 16'(w);
    height = 16'(h);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic applyStimulus(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_pixel = vecs[first + i].pix;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk);
        if (in_ready) acc = 1'b1;
        @(posedge clk); #1;
      end
      if (!acc) begin
        checkOutput($sformatf("in_ready timeout pix %0d", first + i), 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input int d0, input string tag);
    for (int c = 0; c < 100 && done_cnt == d0; c++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
    @(negedge clk);
    checkOutput({tag, " busy after"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic checkFrame(input int first, input int n, input int base, input string tag);
    checkOutput({tag, " out count"}, 64'(q_sum.size() - base), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (base + i < q_sum.size()) begin
        checkOutput($sformatf("%s sum[%0d]", tag, i), 64'(q_sum[base + i]), 64'(vecs[first + i].sum));
        checkOutput($sformatf("%s sqsum[%0d]", tag, i), 64'(q_sq[base + i]),
                    SQ_EN ? 64'(vecs[first + i].sq) : 64'd0);
        checkOutput($sformatf("%s addr[%0d]", tag, i), 64'(q_addr[base + i]), 64'(i));
      end
    end
  endtask

  task automatic runFrame(input int f);
    int base;
    int d0;
    string tag;
    tag  = $sformatf("f%0d", f);
    base = q_sum.size();
    d0   = done_cnt;
    startFrame(frames[f].w, frames[f].h);
    applyStimulus(frames[f].first, frames[f].n);
    waitDone(d0, tag);
    checkFrame(frames[f].first, frames[f].n, base, tag);
  endtask

  initial begin
    int kk [12] = '{1, 2, 3, 4, 2, 4, 6, 8, 3, 6, 9, 12};
    int base;
    int d0;
    int e0;
    int b0;

    vecs[0] = '{8'd1, 32'd1, 48'd1};
    vecs[1] = '{8'd2, 32'd3, 48'd5};
    vecs[2] = '{8'd3, 32'd4, 48'd10};
    vecs[3] = '{8'd4, 32'd10, 48'd30};
    for (int i = 0; i < 12; i++)
      vecs[4 + i] = '{8'd255, 32'(255 * kk[i]), 48'(65025 * kk[i])};
    vecs[16] = '{8'd2, 32'd2, 48'd4};
    vecs[17] = '{8'd3, 32'd5, 48'd13};
    vecs[18] = '{8'd10, 32'd10, 48'd100};
    vecs[19] = '{8'd20, 32'd30, 48'd500};
    vecs[20] = '{8'd30, 32'd60, 48'd1400};
    vecs[21] = '{8'd40, 32'd50, 48'd1700};
    vecs[22] = '{8'd50, 32'd120, 48'd4600};
    vecs[23] = '{8'd60, 32'd210, 48'd9100};
    vecs[24] = '{8'd5, 32'd5, 48'd25};
    vecs[25] = '{8'd6, 32'd11, 48'd61};
    vecs[26] = '{8'd7, 32'd18, 48'd110};
    vecs[27] = '{8'd7, 32'd7, 48'd49};
    vecs[28] = '{8'd8, 32'd15, 48'd113};
    vecs[29] = '{8'd9, 32'd24, 48'd194};

    frames[0] = '{2, 2, 0, 4};
    frames[1] = '{4, 3, 4, 12};
    frames[2] = '{2, 1, 16, 2};
    frames[3] = '{3, 2, 18, 6};
    frames[4] = '{1, 3, 24, 3};

    reset     = 1'b1;
    start     = 1'b0;
    width     = '0;
    height    = '0;
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset err", 64'(err), 64'd0);
    checkOutput("reset out_sum", 64'(out_sum), 64'd0);
    checkOutput("reset out_addr", 64'(out_addr), 64'd0);
    checkOutput("reset out_sqsum", 64'(out_sqsum), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int f = 0; f < 5; f++) runFrame(f);

    // Backpressure: stall the output for several cycles after the first result.
    base = q_sum.size();
    d0   = done_cnt;
    e0   = err_cnt;
    out_ready = 1'b0;
    startFrame(3, 1);
    in_valid = 1'b1;
    in_pixel = vecs[27].pix;
    @(negedge clk);
    checkOutput("bp first in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_pixel = vecs[28].pix;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bp stall%0d out_valid", k), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp stall%0d out_sum", k), 64'(out_sum), 64'd7);
      checkOutput($sformatf("bp stall%0d in_ready", k), 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    startFrame(0, 0);
    out_ready = 1'b1;
    applyStimulus(28, 2);
    waitDone(d0, "bp");
    checkOutput("bp start in RUN no err", 64'(err_cnt - e0), 64'd0);
    checkFrame(27, 3, base, "bp");

    // Rejected starts: zero width, oversize width, zero height.
    e0 = err_cnt;
    b0 = busy_cnt;
    startFrame(0, 4);
    startFrame(MAXW + 1, 4);
    startFrame(3, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err pulse count", 64'(err_cnt - e0), 64'd3);
    checkOutput("err busy stayed low", 64'(busy_cnt - b0), 64'd0);

    // Abandon a max-width frame with reset, then run a fresh 2x2 frame.
    startFrame(MAXW, 8);
    @(negedge clk);
    checkOutput("max width accepted busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    applyStimulus(4, 5);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset in_ready", 64'(in_ready), 64'd0);
    checkOutput("midreset out_sum", 64'(out_sum), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    runFrame(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
